// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin fetch/data arbiter onto one Avalon-style master port
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        reset,
   // fetch requester (read-only)
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_ack,
   output logic        if_busy,
   // data requester
   input  logic        d_req,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byteenable,
   output logic        d_ack,
   output logic        d_busy,
   // shared response
   output logic [31:0] rdata,
   output logic        err,
   // master port
   output logic [31:0] address,
   output logic [31:0] writedata,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   // counter value at which one more stalled cycle means the transfer is abandoned
   localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_XFER,
      S_DONE
   } state_t;

   state_t        state_q;

   // pending request registers, one per requester
   logic          if_pend_q;
   logic [31:0]   if_addr_q;
   logic          d_pend_q;
   logic          d_write_q;
   logic [31:0]   d_addr_q;
   logic [31:0]   d_wdata_q;
   logic [3:0]    d_be_q;

   // last_data_q is both the round-robin history and the current grantee
   logic          last_data_q;
   logic [TW-1:0] tmo_q;

   // registered master-port and response outputs
   logic [31:0]   address_q;
   logic [31:0]   writedata_q;
   logic [3:0]    byteenable_q;
   logic          read_q;
   logic          write_q;
   logic [31:0]   rdata_q;
   logic          if_ack_q;
   logic          d_ack_q;
   logic          err_q;

   logic          grant_data_d;
   logic          tmo_hit_d;

   // pick the data requester when it is the only one pending or the fetch side went last
   always_comb begin
      grant_data_d = d_pend_q & (~if_pend_q | ~last_data_q);
      tmo_hit_d    = 1'b0;
      if (TIMEOUT_CYCLES != 0) begin
         tmo_hit_d = waitrequest & (tmo_q == TMO_LAST);
      end
   end

   // request capture, arbitration FSM, bus strobes and response pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         if_pend_q    <= 1'b0;
         if_addr_q    <= '0;
         d_pend_q     <= 1'b0;
         d_write_q    <= 1'b0;
         d_addr_q     <= '0;
         d_wdata_q    <= '0;
         d_be_q       <= '0;
         last_data_q  <= 1'b1;
         tmo_q        <= '0;
         address_q    <= '0;
         writedata_q  <= '0;
         byteenable_q <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         rdata_q      <= '0;
         if_ack_q     <= 1'b0;
         d_ack_q      <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         // ack and err are single-cycle pulses
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         err_q    <= 1'b0;

         // a requester with nothing pending may post a new request, including in its ack cycle
         if (if_req && !if_pend_q) begin
            if_pend_q <= 1'b1;
            if_addr_q <= if_addr;
         end
         if (d_req && !d_pend_q) begin
            d_pend_q  <= 1'b1;
            d_write_q <= d_write;
            d_addr_q  <= d_addr;
            d_wdata_q <= d_wdata;
            d_be_q    <= d_byteenable;
         end

         case (state_q)
            S_IDLE: begin
               if (if_pend_q || d_pend_q) begin
                  last_data_q <= grant_data_d;
                  tmo_q       <= '0;
                  state_q     <= S_XFER;
                  if (grant_data_d) begin
                     address_q    <= d_addr_q;
                     writedata_q  <= d_write_q ? d_wdata_q : 32'h0;
                     byteenable_q <= d_be_q;
                     read_q       <= ~d_write_q;
                     write_q      <= d_write_q;
                  end else begin
                     address_q    <= if_addr_q;
                     writedata_q  <= 32'h0;
                     byteenable_q <= 4'b1111;
                     read_q       <= 1'b1;
                     write_q      <= 1'b0;
                  end
               end
            end

            S_XFER: begin
               if (!waitrequest || tmo_hit_d) begin
                  // normal completion or abandoned after too many stalled cycles
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  rdata_q <= (!waitrequest && read_q) ? readdata : 32'h0;
                  err_q   <= waitrequest;
                  state_q <= S_DONE;
                  if (last_data_q) begin
                     d_pend_q <= 1'b0;
                     d_ack_q  <= 1'b1;
                  end else begin
                     if_pend_q <= 1'b0;
                     if_ack_q  <= 1'b1;
                  end
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // busy covers the pending/in-flight span plus the ack cycle
   assign if_busy    = if_pend_q | if_ack_q;
   assign d_busy     = d_pend_q | d_ack_q;
   assign if_ack     = if_ack_q;
   assign d_ack      = d_ack_q;
   assign err        = err_q;
   assign rdata      = rdata_q;
   assign address    = address_q;
   assign writedata  = writedata_q;
   assign byteenable = byteenable_q;
   assign read       = read_q;
   assign write      = write_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed vector bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ack;
   logic        if_busy;
   logic        d_req;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_byteenable;
   logic        d_ack;
   logic        d_busy;
   logic [31:0] rdata;
   logic        err;
   logic [31:0] address;
   logic [31:0] writedata;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_ack       (if_ack),
      .if_busy      (if_busy),
      .d_req        (d_req),
      .d_write      (d_write),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_byteenable (d_byteenable),
      .d_ack        (d_ack),
      .d_busy       (d_busy),
      .rdata        (rdata),
      .err          (err),
      .address      (address),
      .writedata    (writedata),
      .read         (read),
      .write        (write),
      .byteenable   (byteenable),
      .waitrequest  (waitrequest),
      .readdata     (readdata)
   );

   always #5 clk = ~clk;

   // inputs applied before an edge, expected outputs observed just after it
   typedef struct {
      logic        ifr;
      logic [31:0] ifa;
      logic        dr;
      logic        dw;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [3:0]  dbe;
      logic        wr;
      logic [31:0] rd;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
      logic [3:0]  e_be;
      logic        e_ifack;
      logic        e_dack;
      logic        e_err;
      logic        e_ifb;
      logic        e_db;
      logic [31:0] e_rdata;
   } vec_t;

   localparam int NV = 31;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [31:0] Z = 32'h0;
   localparam logic [3:0] B0 = 4'h0;

   vec_t tv [0:NV-1];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n_strobe;
      bit  got_ack;
      bit  ack_seen;

      // single fetch read, zero wait states
      tv[0]  = '{H,32'h1000,L,L,Z,Z,B0, L,32'h24020005, L,L,Z,Z,B0,         L,L,L,H,L,Z};
      tv[1]  = '{L,Z,L,L,Z,Z,B0,        L,32'h24020005, H,L,32'h1000,Z,4'hF, L,L,L,H,L,Z};
      tv[2]  = '{L,Z,L,L,Z,Z,B0,        L,32'h24020005, L,L,Z,Z,B0,         H,L,L,H,L,32'h24020005};
      tv[3]  = '{L,Z,L,L,Z,Z,B0,        L,Z,            L,L,Z,Z,B0,         L,L,L,L,L,Z};
      // data write with three stalled cycles
      tv[4]  = '{L,Z,H,H,32'h10,32'hDEADBEEF,4'h3, H,Z, L,L,Z,Z,B0, L,L,L,L,H,Z};
      tv[5]  = '{L,Z,L,L,Z,Z,B0, H,Z,          L,H,32'h10,32'hDEADBEEF,4'h3, L,L,L,L,H,Z};
      tv[6]  = '{L,Z,L,L,Z,Z,B0, H,32'h55AA55AA, L,H,32'h10,32'hDEADBEEF,4'h3, L,L,L,L,H,Z};
      tv[7]  = '{L,Z,L,L,Z,Z,B0, H,32'h55AA55AA, L,H,32'h10,32'hDEADBEEF,4'h3, L,L,L,L,H,Z};
      tv[8]  = '{L,Z,L,L,Z,Z,B0, H,32'h55AA55AA, L,H,32'h10,32'hDEADBEEF,4'h3, L,L,L,L,H,Z};
      tv[9]  = '{L,Z,L,L,Z,Z,B0, L,32'h55AA55AA, L,L,Z,Z,B0, L,H,L,L,H,Z};
      tv[10] = '{L,Z,L,L,Z,Z,B0, L,Z,            L,L,Z,Z,B0, L,L,L,L,L,Z};
      // simultaneous requests, re-posted in each ack cycle: grants go F, D, F, D
      tv[11] = '{H,32'h100,H,L,32'h200,Z,4'h5, L,Z, L,L,Z,Z,B0, L,L,L,H,H,Z};
      tv[12] = '{L,Z,L,L,Z,Z,B0, L,Z,        H,L,32'h100,Z,4'hF, L,L,L,H,H,Z};
      tv[13] = '{L,Z,L,L,Z,Z,B0, L,32'hA1,   L,L,Z,Z,B0, H,L,L,H,H,32'hA1};
      tv[14] = '{H,32'h104,L,L,Z,Z,B0, L,Z,  L,L,Z,Z,B0, L,L,L,H,H,Z};
      tv[15] = '{L,Z,L,L,Z,Z,B0, L,Z,        H,L,32'h200,Z,4'h5, L,L,L,H,H,Z};
      tv[16] = '{L,Z,L,L,Z,Z,B0, L,32'hB2,   L,L,Z,Z,B0, L,H,L,H,H,32'hB2};
      tv[17] = '{L,Z,H,H,32'h204,32'h12345678,4'hC, L,Z, L,L,Z,Z,B0, L,L,L,H,H,Z};
      tv[18] = '{L,Z,L,L,Z,Z,B0, L,Z,        H,L,32'h104,Z,4'hF, L,L,L,H,H,Z};
      tv[19] = '{L,Z,L,L,Z,Z,B0, L,32'hC3,   L,L,Z,Z,B0, H,L,L,H,H,32'hC3};
      tv[20] = '{L,Z,L,L,Z,Z,B0, L,Z,        L,L,Z,Z,B0, L,L,L,L,H,Z};
      tv[21] = '{L,Z,L,L,Z,Z,B0, L,Z,        L,H,32'h204,32'h12345678,4'hC, L,L,L,L,H,Z};
      tv[22] = '{L,Z,L,L,Z,Z,B0, L,32'hD4,   L,L,Z,Z,B0, L,H,L,L,H,Z};
      tv[23] = '{L,Z,L,L,Z,Z,B0, L,Z,        L,L,Z,Z,B0, L,L,L,L,L,Z};
      // fetch re-requests while busy are dropped
      tv[24] = '{H,32'h3000,L,L,Z,Z,B0, L,Z,   L,L,Z,Z,B0, L,L,L,H,L,Z};
      tv[25] = '{H,32'h4000,L,L,Z,Z,B0, L,Z,   H,L,32'h3000,Z,4'hF, L,L,L,H,L,Z};
      tv[26] = '{H,32'h5000,L,L,Z,Z,B0, H,Z,   H,L,32'h3000,Z,4'hF, L,L,L,H,L,Z};
      tv[27] = '{L,Z,L,L,Z,Z,B0, L,32'hE5,     L,L,Z,Z,B0, H,L,L,H,L,32'hE5};
      tv[28] = '{L,Z,L,L,Z,Z,B0, L,Z,          L,L,Z,Z,B0, L,L,L,L,L,Z};
      tv[29] = '{L,Z,L,L,Z,Z,B0, L,Z,          L,L,Z,Z,B0, L,L,L,L,L,Z};
      tv[30] = '{L,Z,L,L,Z,Z,B0, L,Z,          L,L,Z,Z,B0, L,L,L,L,L,Z};

      reset = 1'b1;
      if_req = 1'b0; if_addr = '0;
      d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = '0;
      waitrequest = 1'b0; readdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset state",
          128'({read, write, if_ack, d_ack, err, if_busy, d_busy, address, writedata, byteenable, rdata}),
          128'(0));
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         if_req = tv[i].ifr; if_addr = tv[i].ifa;
         d_req = tv[i].dr; d_write = tv[i].dw; d_addr = tv[i].da;
         d_wdata = tv[i].dwd; d_byteenable = tv[i].dbe;
         waitrequest = tv[i].wr; readdata = tv[i].rd;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d ctrl rd/wr/ifack/dack/err/ifbusy/dbusy", i),
             128'({read, write, if_ack, d_ack, err, if_busy, d_busy}),
             128'({tv[i].e_rd, tv[i].e_wr, tv[i].e_ifack, tv[i].e_dack, tv[i].e_err, tv[i].e_ifb, tv[i].e_db}));
         if (tv[i].e_rd || tv[i].e_wr)
            chk($sformatf("vec%0d bus addr/wdata/be", i),
                128'({address, writedata, byteenable}),
                128'({tv[i].e_addr, tv[i].e_wd, tv[i].e_be}));
         if (tv[i].e_ifack || tv[i].e_dack)
            chk($sformatf("vec%0d rdata", i), 128'(rdata), 128'(tv[i].e_rdata));
      end
      if_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0; readdata = '0;

      // stuck slave: strobe held for four stalled cycles, then ack with err
      if_req = 1'b1; if_addr = 32'h6000; waitrequest = 1'b1; readdata = 32'hFFFF0000;
      @(posedge clk);
      #1;
      if_req = 1'b0;
      n_strobe = 0;
      got_ack = 1'b0;
      for (int k = 0; k < 20 && !got_ack; k++) begin
         @(posedge clk);
         #1;
         if (read) n_strobe++;
         if (if_ack) begin
            got_ack = 1'b1;
            chk("timeout ack/err/read/rdata", 128'({if_ack, err, read, rdata}),
                128'({1'b1, 1'b1, 1'b0, 32'h0}));
         end
      end
      chk("timeout acked within bound", 128'(got_ack), 128'(1'b1));
      chk("timeout strobe cycles", 128'(n_strobe), 128'(4));
      @(posedge clk);
      #1;
      chk("timeout pulse width", 128'({if_ack, err, if_busy}), 128'(3'b000));
      waitrequest = 1'b0; readdata = 32'h00007777;
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'h7000; d_byteenable = 4'hF;
      @(posedge clk);
      #1;
      d_req = 1'b0;
      @(posedge clk);
      #1;
      chk("post-timeout strobe", 128'({read, write, address}), 128'({1'b1, 1'b0, 32'h7000}));
      @(posedge clk);
      #1;
      chk("post-timeout ack", 128'({d_ack, if_ack, err, rdata}), 128'({1'b1, 1'b0, 1'b0, 32'h7777}));
      @(posedge clk);
      #1;

      // reset in the middle of a stalled write
      waitrequest = 1'b1;
      d_req = 1'b1; d_write = 1'b1; d_addr = 32'h80; d_wdata = 32'hCAFEF00D; d_byteenable = 4'hF;
      @(posedge clk);
      #1;
      d_req = 1'b0;
      @(posedge clk);
      #1;
      chk("pre-reset write strobe", 128'({write, d_busy}), 128'(2'b11));
      #2;
      reset = 1'b1;
      #1;
      chk("async reset drops strobes/busy",
          128'({read, write, d_busy, if_busy, d_ack, if_ack, err}), 128'(0));
      ack_seen = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (d_ack || if_ack) ack_seen = 1'b1;
      end
      chk("no ack for abandoned transfer", 128'(ack_seen), 128'(1'b0));
      reset = 1'b0; waitrequest = 1'b0; readdata = 32'h13579BDF;
      if_req = 1'b1; if_addr = 32'h9000;
      d_req = 1'b1; d_write = 1'b0; d_addr = 32'hA000; d_byteenable = 4'h6;
      @(posedge clk);
      #1;
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk);
      #1;
      chk("post-reset tie fetch first", 128'({read, write, address, byteenable}),
          128'({1'b1, 1'b0, 32'h9000, 4'hF}));
      @(posedge clk);
      #1;
      chk("post-reset fetch ack at E2", 128'({if_ack, d_ack, err, rdata}),
          128'({1'b1, 1'b0, 1'b0, 32'h13579BDF}));
      readdata = 32'h2468ACE0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("post-reset tie data second", 128'({read, write, address, byteenable}),
          128'({1'b1, 1'b0, 32'hA000, 4'h6}));
      @(posedge clk);
      #1;
      chk("post-reset data ack", 128'({if_ack, d_ack, err, rdata, if_busy, d_busy}),
          128'({1'b0, 1'b1, 1'b0, 32'h2468ACE0, 1'b0, 1'b1}));
      @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, number of consecutive waitrequest-high cycles before a transfer is aborted; 0 disables the timeout.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 if_req  in  1  fetch request pulse (read-only requester).
REQ-005 if_addr  in  32  fetch address, sampled with if_req.
REQ-006 if_ack  out  1  one-cycle pulse: fetch transfer finished.
REQ-007 if_busy  out  1  fetch request pending or in flight.
REQ-008 d_req  in  1  data request pulse.
REQ-009 d_write  in  1  1 = write, 0 = read; sampled with d_req.
REQ-010 d_addr, d_wdata  in  32 each  data address and write data, sampled with d_req.
REQ-011 d_byteenable  in  4  data byte lanes, sampled with d_req.
REQ-012 d_ack  out  1  one-cycle pulse: data transfer finished.
REQ-013 d_busy  out  1  data request pending or in flight.
REQ-014 rdata  out  32  read data, valid while if_ack or d_ack is high.
REQ-015 err  out  1  one-cycle pulse coincident with an ack when that transfer timed out.
REQ-016 address, writedata  out  32 each; read, write  out  1 each; byteenable  out  4  Avalon-style master port.
REQ-017 waitrequest  in  1; readdata  in  32  slave response.

Function
REQ-018 A request is captured into that requester's pending register (address, data, byteenable, direction) at the edge where req=1 and busy=0; req while busy=1 is ignored.
REQ-019 Fetch requests always drive byteenable=4'b1111, read=1, write=0.
REQ-020 States: IDLE, XFER, DONE.
REQ-021 IDLE: if any pending, grant one, load bus outputs from its pending register, go to XFER; else stay.
REQ-022 Arbitration is round-robin: if both are pending, grant the requester not granted last; after reset, fetch wins the first tie.
REQ-023 XFER: exactly one of read/write is held at 1 and the address/writedata/byteenable are held stable until completion.
REQ-024 Completion = rising edge in XFER with waitrequest=0: drop read/write, register readdata into rdata (writes give rdata=0), clear the grantee's pending, go to DONE.
REQ-025 DONE: the grantee's ack is 1 for exactly this cycle; next state IDLE.
REQ-026 Minimum latency: req sampled at edge E0 -> strobe visible E1-E2 -> ack visible E2-E3 (zero wait states).
REQ-027 Timeout counter: cleared on entering XFER; increments each XFER cycle with waitrequest=1; on reaching TIMEOUT_CYCLES: abort, drop strobes, rdata=0, ack and err pulse in DONE, pending cleared.
REQ-028 busy stays 1 from the capture edge through the ack cycle; a new req is accepted in the ack cycle itself.
REQ-029 A requester's ack never asserts for a transfer it did not request; if_ack and d_ack are never high together.
REQ-030 Only one transfer is in flight; the non-granted pending request waits without loss and is granted at the next IDLE.

Reset
REQ-031 reset=1 asynchronously forces IDLE, clears both pending flags and the timeout counter, sets last-grant to data, and drives read, write, if_ack, d_ack, err, if_busy, d_busy to 0 and address, writedata, byteenable, rdata to 0.
REQ-032 Reset during XFER abandons the transfer with no ack; the first request after reset release is handled normally.

Verification
REQ-033 if_req addr 0x0000_1000, waitrequest=0, readdata 0x2402_0005 -> read=1 at E1, if_ack at E2 with rdata=0x2402_0005, err=0.
REQ-034 d_req write addr 0x10, wdata 0xDEAD_BEEF, byteenable 4'b0011, waitrequest high 3 cycles -> write held 4 cycles with stable fields, d_ack once, rdata=0.
REQ-035 if_req and d_req at same edge after reset -> fetch granted first, data second; four simultaneous pairs in a row alternate grants.
REQ-036 TIMEOUT_CYCLES=4, waitrequest stuck at 1 -> strobe drops after 4 wait cycles, ack+err pulse, rdata=0; next request completes normally.
REQ-037 Reset asserted mid-XFER -> read/write drop immediately, no ack, busy=0; a read issued after release completes in 2 cycles.
REQ-038 Second if_req while if_busy=1 -> ignored; exactly one if_ack is produced.
